// File: rtl/ej_sipo_rx.sv
// ej_sipo_rx: serial-in / parallel-out receiver with a ready/valid output handshake.
// Bits are assembled LSB-first or MSB-first into a right-justified word of
// L = min(sh+1, WIDTH) bits. Direction and length are latched on the first bit of each word.
// A finished word is held until the consumer takes it. Bits that arrive while the word is
// held, and that have no handshake, are dropped and set a sticky overrun flag.
// Optional feature macro: EJ_SIPO_PARITY_EN. When it is defined, one even-parity bit
// follows the data bits of each word and is checked against them.
module ej_sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             shift_r_l,
  input  logic [2:0]       sh,
  input  logic             d_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [3:0] LW = 4'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
`ifdef EJ_SIPO_PARITY_EN
    S_PARITY  = 2'd2,
`endif
    S_HOLD    = 2'd3
  } state_t;

  // State entered once the last data bit of a word has been accepted.
`ifdef EJ_SIPO_PARITY_EN
  localparam state_t S_DATA_DONE = S_PARITY;
`else
  localparam state_t S_DATA_DONE = S_HOLD;
`endif

  state_t           r_state;
  state_t           w_state_next;

  // Per-word configuration that was latched on the first bit, plus the assembly progress.
  logic             r_lsb_first;
  logic [3:0]       r_len;
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_shift;

  // Output registers. d_out only changes when a new word is presented.
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_overrun;

  logic [3:0]       w_len_in;
  logic             w_start;
  logic             w_take;
  logic             w_data_done;
  logic             w_word_done;
  logic             w_handshake;
  logic             w_drop;
  logic [3:0]       w_pos;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_word;

  // Effective word length from the live sh input, clamped to the output width.
  always_comb begin
    w_len_in = {1'b0, sh} + 4'd1;
    if (w_len_in > LW) begin
      w_len_in = LW;
    end
  end

  // Next-state logic. It also decides whether the current bit starts a word, extends one,
  // completes one, or is dropped.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_take       = 1'b0;
    w_data_done  = 1'b0;
    w_word_done  = 1'b0;
    w_handshake  = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bit_valid) begin
          w_start = 1'b1;
          if (w_len_in == 4'd1) begin
            w_data_done  = 1'b1;
            w_state_next = S_DATA_DONE;
          end else begin
            w_state_next = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (bit_valid) begin
          w_take = 1'b1;
          if (r_count + 4'd1 == r_len) begin
            w_data_done  = 1'b1;
            w_state_next = S_DATA_DONE;
          end
        end
      end
`ifdef EJ_SIPO_PARITY_EN
      S_PARITY: begin
        if (bit_valid) begin
          w_word_done  = 1'b1;
          w_state_next = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (d_ready) begin
          w_handshake = 1'b1;
          if (bit_valid) begin
            // The consumer takes the held word and this bit begins the next one.
            w_start = 1'b1;
            if (w_len_in == 4'd1) begin
              w_data_done  = 1'b1;
              w_state_next = S_DATA_DONE;
            end else begin
              w_state_next = S_COLLECT;
            end
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (bit_valid) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
`ifndef EJ_SIPO_PARITY_EN
    w_word_done = w_data_done;
`endif
  end

  // Bit position of the incoming bit. A new word uses the live direction and length.
  // A word already in progress uses the latched ones.
  always_comb begin
    w_pos = 4'd0;
    if (w_start) begin
      w_pos = shift_r_l ? 4'd0 : (w_len_in - 4'd1);
    end else begin
      w_pos = r_lsb_first ? r_count : (r_len - 4'd1 - r_count);
    end
  end

  // Per-bit update of the assembly register. Starting a word clears every other bit,
  // so the bits above L stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      assign w_shift_next[gi] = w_start ? (bit_in & (w_pos == 4'(gi)))
                              : ((w_take && (w_pos == 4'(gi))) ? bit_in : r_shift[gi]);
    end
  endgenerate

`ifdef EJ_SIPO_PARITY_EN
  // With parity, the data bits are complete before the parity bit arrives.
  assign w_word = r_shift;
`else
  // Without parity, the word includes the bit that is accepted this cycle.
  assign w_word = w_shift_next;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Word assembly: latch the configuration on the first bit and store each accepted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lsb_first <= 1'b0;
      r_len       <= 4'd0;
      r_count     <= 4'd0;
      r_shift     <= '0;
    end else if (w_start) begin
      r_lsb_first <= shift_r_l;
      r_len       <= w_len_in;
      r_count     <= 4'd1;
      r_shift     <= w_shift_next;
    end else if (w_take) begin
      r_count     <= r_count + 4'd1;
      r_shift     <= w_shift_next;
    end
  end

  // Output word and valid. Completing a word has priority over clearing valid, so
  // back-to-back words keep d_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else if (w_word_done) begin
      r_dout   <= w_word;
      r_dvalid <= 1'b1;
    end else if (w_handshake) begin
      r_dvalid <= 1'b0;
    end
  end

  // Sticky overrun: set by any bit dropped while a word is held. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef EJ_SIPO_PARITY_EN
  logic r_parity_err;

  // Parity result is registered together with the word and cleared when the word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_word_done) begin
      r_parity_err <= ^{r_shift, bit_in};
    end else if (w_handshake) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign d_out   = r_dout;
  assign d_valid = r_dvalid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_ej_sipo_rx.sv
// Bench for ej_sipo_rx. A queue-based model of the receiver is checked every cycle,
// and directed words are checked against hand-computed literal values.
// The parity scenarios are built when EJ_SIPO_PARITY_EN is defined.
module tb_ej_sipo_rx;

  localparam int WIDTH = 8;
`ifdef EJ_SIPO_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             shift_r_l = 1'b0;
  logic [2:0]       sh = 3'd7;
  logic             d_ready = 1'b1;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             overrun;
  logic             parity_err;

  int errors = 0;
  int checks = 0;

  ej_sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .shift_r_l  (shift_r_l),
    .sh         (sh),
    .d_ready    (d_ready),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. The bits of the current word are kept in a queue. A word is
  // produced once L (+ parity) bits have arrived, and each bit is placed by simple
  // position arithmetic.
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;
  bit         m_perr = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_len = 1;
  bit         m_lsb = 1'b0;
  bit         q[$];
  bit         m_acc;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      m_word  = 8'h00;
      q.delete();
    end else begin
      m_acc = bit_valid && (!m_valid || d_ready);
      if (bit_valid && m_valid && !d_ready) m_ovr = 1'b1;
      if (m_valid && d_ready) begin
        m_valid = 1'b0;
        m_perr  = 1'b0;
      end
      if (m_acc) begin
        if (q.size() == 0) begin
          m_lsb = shift_r_l;
          m_len = (int'(sh) + 1 > WIDTH) ? WIDTH : int'(sh) + 1;
        end
        q.push_back(bit_in);
        if (q.size() == m_len + PBITS) begin
          m_word = 8'h00;
          for (int i = 0; i < m_len; i++)
            if (q[i]) m_word[m_lsb ? i : m_len - 1 - i] = 1'b1;
          m_perr = 1'b0;
          if (PBITS != 0)
            foreach (q[i]) m_perr = m_perr ^ q[i];
          m_valid = 1'b1;
          q.delete();
        end
      end
    end
  end

  // Compare the DUT with the model every cycle, shortly after the clock edge.
  always @(posedge clk) begin
    #1;
    chk("cyc d_valid", d_valid, m_valid);
    chk("cyc overrun", overrun, m_ovr);
    chk("cyc parity_err", parity_err, m_valid ? m_perr : 1'b0);
    if (m_valid) chk("cyc d_out", d_out, m_word);
  end

  // Send a word given as a bit string (leftmost bit first). After the last bit, check
  // d_valid, d_out and parity one clock later against literal values. If toggle is set,
  // shift_r_l and sh change after the first bit, which must have no effect on the word.
  task automatic send(input string name, input bit lsb, input logic [2:0] shv,
                      input logic [8:0] seq, input int n, input bit rdy,
                      input bit toggle, input bit gap, input logic [7:0] lit,
                      input bit lit_perr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      bit_valid = 1'b1;
      bit_in    = seq[n - 1 - i];
      d_ready   = rdy;
      shift_r_l = (toggle && i > 0) ? ~lsb : lsb;
      sh        = (toggle && i > 0) ? 3'd3 : shv;
      if (gap && i < n - 1) begin
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = ~bit_in;
      end
    end
    @(posedge clk);
    #1;
    chk({name, " d_valid"}, d_valid, 1'b1);
    chk({name, " d_out"}, d_out, lit);
    chk({name, " model"}, m_word, lit);
    chk({name, " parity_err"}, parity_err, lit_perr);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset d_out", d_out, 8'h00);
    chk("reset d_valid", d_valid, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef EJ_SIPO_PARITY_EN
    send("par_ok", 1'b0, 3'd7, 9'b101010100, 9, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    @(posedge clk); #1;
    chk("par_ok cleared", parity_err, 1'b0);
    send("par_err", 1'b0, 3'd7, 9'b101010110, 9, 1'b1, 1'b0, 1'b0, 8'hAB, 1'b1);
    @(posedge clk); #1;
    chk("par_err cleared", parity_err, 1'b0);
    chk("par_err valid drop", d_valid, 1'b0);
`else
    // MSB first, full width. d_valid is high for exactly one cycle when d_ready is high.
    send("msb_aa", 1'b0, 3'd7, 9'b010101010, 8, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    @(posedge clk); #1;
    chk("msb_aa one cycle", d_valid, 1'b0);

    // LSB first. In the second copy, direction and length change mid-word.
    send("lsb_ee", 1'b1, 3'd7, 9'b001110111, 8, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0);
    send("lsb_ee_tog", 1'b1, 3'd7, 9'b001110111, 8, 1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);

    // Short words in both directions.
    send("msb_4", 1'b0, 3'd3, 9'b000001011, 4, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b0);
    send("lsb_4", 1'b1, 3'd3, 9'b000001011, 4, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b0);

    // Single-bit word, and a 5-bit LSB-first word with idle gaps between bits.
    send("len1", 1'b0, 3'd0, 9'b000000001, 1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
    send("lsb5_gap", 1'b1, 3'd4, 9'b000010011, 5, 1'b1, 1'b0, 1'b1, 8'h19, 1'b0);

    // Held word with bits dropped, then a handshake that coincides with the next first bit.
    send("hold_aa", 1'b0, 3'd7, 9'b010101010, 8, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
    end
    @(posedge clk); #1;
    chk("hold d_out", d_out, 8'hAA);
    chk("hold overrun", overrun, 1'b1);
    chk("hold d_valid", d_valid, 1'b1);
    send("after_hold", 1'b0, 3'd3, 9'b000001011, 4, 1'b1, 1'b0, 1'b0, 8'h0B, 1'b0);
    chk("overrun sticky", overrun, 1'b1);

    // Partial word, reset while a bit is valid, then a full word right after reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = i[0];
      shift_r_l = 1'b0;
      sh        = 3'd7;
    end
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    send("post_rst_55", 1'b0, 3'd7, 9'b001010101, 8, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    chk("post_rst overrun", overrun, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
